// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor slice.
//   kind_e      : BTB entry kind (conditional branch or JAL)
//   SNT..ST     : 2-bit confidence counter encodings
//   btb_entry_t : one BTB entry; tag holds pc >> (IDX_W+2) right-justified
//   sat_inc/dec : saturating counter steps
package bp_pkg;

  typedef enum logic {
    BR  = 1'b0,
    JAL = 1'b1
  } kind_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic        valid;
    kind_e       kind;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational 2-bit saturating counter step.
//   ctr      in  current counter value
//   taken    in  1 = step up, 0 = step down
//   ctr_nxt  out next counter value (saturates at SNT and ST)
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = taken ? sat_inc(ctr) : sat_dec(ctr);
  end

endmodule

// File: rtl/branch_predictor_if.sv
// IF-side branch predictor: direct-mapped BTB with 2-bit counters.
//   clk, rstn                     clock, async active-low reset
//   pc_IF                         fetch PC to predict
//   predtaken_IF, predtarget_IF   prediction for pc_IF (target 0 when not taken)
//   ex_valid, pc_EX, pcnext_EX,
//   pcimm_EX, branch_EX, btaken_EX,
//   jal_EX, jalr_EX, ctarget      EX-stage resolution of the instruction in EX
//   predtaken_EX, predtarget_EX   prediction that was made for it at IF
//   redirect, redirect_pc         mispredict flush request and correct next PC
//   br_cnt, mis_cnt               resolved control-flow / redirect counters
module branch_predictor_if
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      pc_IF,
  output logic             predtaken_IF,
  output logic [31:0]      predtarget_IF,
  input  logic             ex_valid,
  input  logic [31:0]      pc_EX,
  input  logic [31:0]      pcnext_EX,
  input  logic [31:0]      pcimm_EX,
  input  logic             branch_EX,
  input  logic             btaken_EX,
  input  logic             jal_EX,
  input  logic             jalr_EX,
  input  logic [31:0]      ctarget,
  input  logic             predtaken_EX,
  input  logic [31:0]      predtarget_EX,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  btb_entry_t btb [ENTRIES];

  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [31:0]      tag_if, tag_ex;
  btb_entry_t       e_if, e_ex;
  logic             hit_if, hit_ex;
  logic [1:0]       ctr_nxt;

  logic             is_ctrl, actual_taken;
  logic [31:0]      actual_pc;

  assign idx_if = pc_IF[IDX_W+1:2];
  assign idx_ex = pc_EX[IDX_W+1:2];
  assign tag_if = pc_IF >> (IDX_W + 2);
  assign tag_ex = pc_EX >> (IDX_W + 2);

  // Lookup reads the pre-update table; no bypass from the EX write.
  always_comb begin
    e_if          = btb[idx_if];
    hit_if        = e_if.valid && (e_if.tag == tag_if);
    predtaken_IF  = hit_if && ((e_if.kind == JAL) || e_if.ctr[1]);
    predtarget_IF = predtaken_IF ? e_if.target : '0;
  end

  always_comb begin
    is_ctrl      = branch_EX || jal_EX || jalr_EX;
    actual_taken = (branch_EX && btaken_EX) || jal_EX || jalr_EX;
    actual_pc    = (jal_EX || jalr_EX) ? pcimm_EX : ctarget;
    // Held low during reset so every output reads 0 while rstn is asserted.
    redirect     = rstn && ex_valid && (is_ctrl || predtaken_EX) &&
                   ((predtaken_EX != actual_taken) ||
                    (actual_taken && (predtarget_EX != actual_pc)));
    redirect_pc  = redirect ? (actual_taken ? actual_pc : pcnext_EX) : '0;
  end

  always_comb begin
    e_ex   = btb[idx_ex];
    hit_ex = e_ex.valid && (e_ex.tag == tag_ex);
  end

  bp_sat_counter u_sat (
    .ctr     (e_ex.ctr),
    .taken   (btaken_EX),
    .ctr_nxt (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].kind   <= BR;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= WNT;
      end
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (ex_valid) begin
        // JALR never touches the table: its target is register-dependent.
        if (jal_EX) begin
          btb[idx_ex].valid  <= 1'b1;
          btb[idx_ex].kind   <= JAL;
          btb[idx_ex].tag    <= tag_ex;
          btb[idx_ex].target <= pcimm_EX;
          btb[idx_ex].ctr    <= ST;
        end else if (branch_EX) begin
          if (hit_ex) begin
            btb[idx_ex].ctr <= ctr_nxt;
            if (btaken_EX) btb[idx_ex].target <= pcimm_EX;
          end else if (btaken_EX) begin
            btb[idx_ex].valid  <= 1'b1;
            btb[idx_ex].kind   <= BR;
            btb[idx_ex].tag    <= tag_ex;
            btb[idx_ex].target <= pcimm_EX;
            btb[idx_ex].ctr    <= WT;
          end
        end
        if (is_ctrl) br_cnt <= br_cnt + CNT_W'(1);
      end
      if (redirect) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_if.sv
module tb_branch_predictor_if;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc_IF;
  logic        predtaken_IF;
  logic [31:0] predtarget_IF;
  logic        ex_valid;
  logic [31:0] pc_EX, pcnext_EX, pcimm_EX, ctarget, predtarget_EX;
  logic        branch_EX, btaken_EX, jal_EX, jalr_EX, predtaken_EX;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt, mis_cnt;

  branch_predictor_if #(.IDX_W(4), .CNT_W(32)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pc_IF         (pc_IF),
    .predtaken_IF  (predtaken_IF),
    .predtarget_IF (predtarget_IF),
    .ex_valid      (ex_valid),
    .pc_EX         (pc_EX),
    .pcnext_EX     (pcnext_EX),
    .pcimm_EX      (pcimm_EX),
    .branch_EX     (branch_EX),
    .btaken_EX     (btaken_EX),
    .jal_EX        (jal_EX),
    .jalr_EX       (jalr_EX),
    .ctarget       (ctarget),
    .predtaken_EX  (predtaken_EX),
    .predtarget_EX (predtarget_EX),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .br_cnt        (br_cnt),
    .mis_cnt       (mis_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-slot remembered pc, kind, target and a 0..3 confidence.
  bit          m_valid [16];
  bit          m_jal   [16];
  int unsigned m_pchi  [16];
  int unsigned m_tgt   [16];
  int          m_conf  [16];
  int unsigned exp_br, exp_mis;

  function automatic int unsigned slot(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_jal[i] = 0; m_pchi[i] = 0; m_tgt[i] = 0; m_conf[i] = 1;
    end
    exp_br = 0; exp_mis = 0;
  endfunction

  function automatic bit model_hit(input int unsigned pc);
    return m_valid[slot(pc)] && (m_pchi[slot(pc)] == pc / 64);
  endfunction

  function automatic void model_predict(input int unsigned pc, output bit t,
                                        output int unsigned tgt);
    t   = model_hit(pc) && (m_jal[slot(pc)] || m_conf[slot(pc)] >= 2);
    tgt = t ? m_tgt[slot(pc)] : 0;
  endfunction

  function automatic void model_update(input int unsigned pc, input bit br, input bit tk,
                                       input bit jl, input int unsigned imm);
    int unsigned s = slot(pc);
    if (jl) begin
      m_valid[s] = 1; m_jal[s] = 1; m_pchi[s] = pc / 64; m_tgt[s] = imm; m_conf[s] = 3;
    end else if (br) begin
      if (model_hit(pc)) begin
        m_conf[s] = tk ? ((m_conf[s] + 1 > 3) ? 3 : m_conf[s] + 1)
                       : ((m_conf[s] - 1 < 0) ? 0 : m_conf[s] - 1);
        if (tk) m_tgt[s] = imm;
      end else if (tk) begin
        m_valid[s] = 1; m_jal[s] = 0; m_pchi[s] = pc / 64; m_tgt[s] = imm; m_conf[s] = 2;
      end
    end
  endfunction

  task automatic set_ex(input bit v, input int unsigned pc, input bit br, input bit tk,
                        input bit jl, input bit jr, input int unsigned imm,
                        input bit pt, input int unsigned ptg);
    ex_valid      = v;
    pc_EX         = pc;
    pcnext_EX     = pc + 4;
    pcimm_EX      = imm;
    branch_EX     = br;
    btaken_EX     = tk;
    jal_EX        = jl;
    jalr_EX       = jr;
    ctarget       = tk ? imm : pc + 4;
    predtaken_EX  = pt;
    predtarget_EX = ptg;
  endtask

  // Called at a negedge with inputs set; checks, crosses one posedge, advances model.
  task automatic apply();
    bit          pt, at, rd, ctrl;
    int unsigned ptg, apc, rpc;
    #1;
    model_predict(pc_IF, pt, ptg);
    ctrl = branch_EX || jal_EX || jalr_EX;
    at   = (branch_EX && btaken_EX) || jal_EX || jalr_EX;
    apc  = (jal_EX || jalr_EX) ? pcimm_EX : ctarget;
    rd   = ex_valid && (ctrl || predtaken_EX) &&
           ((predtaken_EX != at) || (at && predtarget_EX != apc));
    rpc  = rd ? (at ? apc : pcnext_EX) : 0;
    check("predtaken_IF", 32'(predtaken_IF), 32'(pt));
    check("predtarget_IF", predtarget_IF, ptg);
    check("redirect", 32'(redirect), 32'(rd));
    check("redirect_pc", redirect_pc, rpc);
    check("br_cnt", br_cnt, exp_br);
    check("mis_cnt", mis_cnt, exp_mis);
    @(posedge clk);
    if (ex_valid) begin
      model_update(pc_EX, branch_EX, btaken_EX, jal_EX, pcimm_EX);
      if (ctrl) exp_br++;
    end
    if (rd) exp_mis++;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_predtaken"}, 32'(predtaken_IF), 32'd0);
    check({tag, "_predtarget"}, predtarget_IF, 32'd0);
    check({tag, "_redirect"}, 32'(redirect), 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    check({tag, "_br_cnt"}, br_cnt, 32'd0);
    check({tag, "_mis_cnt"}, mis_cnt, 32'd0);
  endtask

  // Reset asserted at a negedge while an active taken branch sits in EX.
  task automatic reset_mid();
    set_ex(1, 32'h13C, 1, 1, 0, 0, 32'h17C, 0, 0);
    rstn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pc_IF = 32'h13C;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();
  endtask

  // Instruction kind is fixed per pc so each address behaves like real code.
  function automatic int unsigned kind_of(input int unsigned pc);
    int unsigned k = (pc / 4) % 8;
    if (k == 7) return 0;
    if (k == 3) return 3;
    if (k == 2 || k == 6) return 2;
    return 1;
  endfunction

  function automatic int unsigned rand_pc();
    int unsigned base;
    case ($urandom_range(0, 2))
      0:       base = 32'h100;
      1:       base = 32'h500;
      default: base = 32'h900;
    endcase
    return base + 4 * $urandom_range(0, 7);
  endfunction

  initial begin
    bit          pt;
    int unsigned ptg;

    rstn = 1'b0;
    pc_IF = 32'h100;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    apply();

    // Taken BEQ at 0x100 to 0x140, not predicted.
    set_ex(1, 32'h100, 1, 1, 0, 0, 32'h140, 0, 0);
    #1;
    check("beq_redirect", 32'(redirect), 32'd1);
    check("beq_redirect_pc", redirect_pc, 32'h140);
    apply();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("beq_predtaken", 32'(predtaken_IF), 32'd1);
    check("beq_predtarget", predtarget_IF, 32'h140);
    apply();

    // Same branch not-taken twice, prediction carried from the model.
    repeat (2) begin
      model_predict(32'h100, pt, ptg);
      set_ex(1, 32'h100, 1, 0, 0, 0, 32'h140, pt, ptg);
      apply();
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("beq_cold_predtaken", 32'(predtaken_IF), 32'd0);
    apply();

    reset_mid();

    // JAL at 0x200 to 0x300 twice: only the first redirects.
    pc_IF = 32'h200;
    repeat (2) begin
      model_predict(32'h200, pt, ptg);
      set_ex(1, 32'h200, 0, 0, 1, 0, 32'h300, pt, ptg);
      apply();
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("jal_br_cnt", br_cnt, 32'd2);
    check("jal_mis_cnt", mis_cnt, 32'd1);
    apply();

    // JALR at 0x180 to 0x400: redirects, never allocates.
    set_ex(1, 32'h180, 0, 0, 0, 1, 32'h400, 0, 0);
    #1;
    check("jalr_redirect_pc", redirect_pc, 32'h400);
    apply();
    pc_IF = 32'h180;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();

    // Bubble carrying a taken branch: no effect anywhere.
    set_ex(0, 32'h1C0, 1, 1, 0, 0, 32'h240, 0, 0);
    apply();
    pc_IF = 32'h1C0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();

    // Randomized traffic, including aliasing pcs, wrong predictions and resets.
    for (int n = 0; n < 600; n++) begin
      int unsigned pc, k, imm;
      bit          v, tk;
      pc = rand_pc();
      k  = kind_of(pc);
      v  = ($urandom_range(0, 7) != 0);
      tk = (k == 1) && ($urandom_range(0, 2) != 0);
      case (k)
        3:       imm = $urandom_range(0, 1) ? 32'h400 : 32'h800;
        0:       imm = $urandom & 32'hFFFC;
        default: imm = pc + 32'h40;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        pt  = $urandom_range(0, 1);
        ptg = pt ? (($urandom_range(0, 1) != 0) ? pc + 32'h40 : 32'h400) : 0;
      end else begin
        model_predict(pc, pt, ptg);
      end
      pc_IF = rand_pc();
      set_ex(v, pc, k == 1, tk, k == 2, k == 3, imm, pt, ptg);
      if ($urandom_range(0, 149) == 0) reset_mid();
      else apply();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
